// File: rtl/conv_pkg.sv
// Shared definitions for the two-layer convolution pipeline.
//   - state_e      : feature-map scheduler FSM states
//   - map_h1/map_w1: layer-1 output map size for a given input image size
//   - fmap_depth   : number of words in the layer-1 feature map
//   - cnt_w        : counter width that still works for a range of one value
//   - col_row_lsb  : column-word packing, row i at [i*DATA_W +: DATA_W]
//                    ({row2, row1, row0}, row0 in the LSBs); used by the
//                    layer-2 units to unpack the same word.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_OUT,
    ST_DONE
  } state_e;

  localparam int KROWS = 3;
  localparam int KCOLS = 3;

  function automatic int map_h1(input int img_h);
    return img_h - 2;
  endfunction

  function automatic int map_w1(input int img_w);
    return img_w - 2;
  endfunction

  function automatic int fmap_depth(input int nf, input int img_h, input int img_w);
    return nf * map_h1(img_h) * map_w1(img_w);
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int col_row_lsb(input int row, input int data_w);
    return row * data_w;
  endfunction

endpackage

// File: rtl/fmap_window_addr_gen.sv
// Read-window address generator for the layer-2 column fetch.
// Holds the r/c/f/k counters (r outermost, k innermost) and forms the BRAM
// address A(i) = ((r+i)*W1 + c+k)*NF + f for the selected kernel row i.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : zero all counters (new frame)
//   adv_i      : step to the next column (k, then f, then c, then r)
//   row_sel_i  : kernel row i (0..2) used for addr_o
//   addr_o     : A(row_sel_i)
//   f_o, k_o   : current filter and kernel-column indices
//   last_o     : all counters at their maxima (final column of the frame)
module fmap_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_H       = 224,
  parameter int IMG_W       = 224,
  parameter int NUM_FILTERS = 3,
  parameter int ADDR_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            adv_i,
  input  logic [1:0]                      row_sel_i,
  output logic [ADDR_W-1:0]               addr_o,
  output logic [cnt_w(NUM_FILTERS)-1:0]   f_o,
  output logic [1:0]                      k_o,
  output logic                            last_o
);

  localparam int RN  = IMG_H - 4;
  localparam int CN  = IMG_W - 4;
  localparam int W1  = map_w1(IMG_W);
  localparam int R_W = cnt_w(RN);
  localparam int C_W = cnt_w(CN);
  localparam int F_W = cnt_w(NUM_FILTERS);

  logic [R_W-1:0] r_q, r_d;
  logic [C_W-1:0] c_q, c_d;
  logic [F_W-1:0] f_q, f_d;
  logic [1:0]     k_q, k_d;

  logic r_max, c_max, f_max, k_max;

  assign r_max = (r_q == R_W'(RN - 1));
  assign c_max = (c_q == C_W'(CN - 1));
  assign f_max = (f_q == F_W'(NUM_FILTERS - 1));
  assign k_max = (k_q == 2'(KCOLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
      f_q <= '0;
      k_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      f_q <= f_d;
      k_q <= k_d;
    end
  end

  // Nested odometer: each counter wraps and carries into the next outer one.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    f_d = f_q;
    k_d = k_q;
    if (clr_i) begin
      r_d = '0;
      c_d = '0;
      f_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      if (k_max) begin
        k_d = '0;
        if (f_max) begin
          f_d = '0;
          if (c_max) begin
            c_d = '0;
            r_d = r_max ? '0 : r_q + R_W'(1);
          end else begin
            c_d = c_q + C_W'(1);
          end
        end else begin
          f_d = f_q + F_W'(1);
        end
      end else begin
        k_d = k_q + 2'd1;
      end
    end
  end

  // Every intermediate value is below the map depth, so ADDR_W bits suffice.
  assign addr_o = ((ADDR_W'(r_q) + ADDR_W'(row_sel_i)) * ADDR_W'(W1)
                   + ADDR_W'(c_q) + ADDR_W'(k_q)) * ADDR_W'(NUM_FILTERS)
                  + ADDR_W'(f_q);

  assign f_o    = f_q;
  assign k_o    = k_q;
  assign last_o = r_max & c_max & f_max & k_max;

endmodule

// File: rtl/conv_fmap_scheduler.sv
// Feature-map BRAM sequencer between the layer-1 conv units, the shared
// single-port feature-map BRAM and the layer-2 conv units.
// Phase 1 (WRITE): accept the layer-1 stream and write it to BRAM in arrival
// order (filter-minor). Phase 2 (RD0..OUT): fetch each 3-row kernel column and
// present it on the column stream, tagged with filter and kernel column.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a frame (honoured in IDLE/DONE only)
//   busy, done          : frame in progress / frame finished
//   l1_valid/ready/data : layer-1 input stream
//   bram_we/addr/din    : BRAM write enable, address, write data
//   bram_dout           : BRAM read data, one cycle after the address
//   col_valid/ready     : column output stream
//   col_data            : {row2, row1, row0}, row0 in the LSBs
//   col_filter, col_k   : filter and kernel-column tags
//   col_last            : final column of the frame
//   dbg_state           : current FSM state
// Both streams use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds valid and its payload
// stable until that edge, and ready may depend on nothing but local state.
module conv_fmap_scheduler
  import conv_pkg::*;
#(
  parameter int DATA_W      = 22,
  parameter int IMG_H       = 224,
  parameter int IMG_W       = 224,
  parameter int NUM_FILTERS = 3,
  parameter int ADDR_W      = $clog2(fmap_depth(NUM_FILTERS, IMG_H, IMG_W))
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          l1_valid,
  output logic                          l1_ready,
  input  logic [DATA_W-1:0]             l1_data,
  output logic                          bram_we,
  output logic [ADDR_W-1:0]             bram_addr,
  output logic [DATA_W-1:0]             bram_din,
  input  logic [DATA_W-1:0]             bram_dout,
  output logic                          col_valid,
  input  logic                          col_ready,
  output logic [KROWS*DATA_W-1:0]       col_data,
  output logic [cnt_w(NUM_FILTERS)-1:0] col_filter,
  output logic [1:0]                    col_k,
  output logic                          col_last,
  output state_e                        dbg_state
);

  localparam int DEPTH = fmap_depth(NUM_FILTERS, IMG_H, IMG_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   row0_q, row1_q, row2_q;

  logic                gen_clr, gen_adv, gen_last;
  logic [1:0]          gen_row_sel;
  logic [ADDR_W-1:0]   gen_addr;

  fmap_window_addr_gen #(
    .IMG_H      (IMG_H),
    .IMG_W      (IMG_W),
    .NUM_FILTERS(NUM_FILTERS),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (gen_clr),
    .adv_i    (gen_adv),
    .row_sel_i(gen_row_sel),
    .addr_o   (gen_addr),
    .f_o      (col_filter),
    .k_o      (col_k),
    .last_o   (gen_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Read data lags the address by one cycle, so RDn+1 captures row n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row0_q <= '0;
      row1_q <= '0;
      row2_q <= '0;
    end else begin
      if (state_q == ST_RD1) row0_q <= bram_dout;
      if (state_q == ST_RD2) row1_q <= bram_dout;
      if (state_q == ST_RD3) row2_q <= bram_dout;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    gen_clr     = 1'b0;
    gen_adv     = 1'b0;
    gen_row_sel = 2'd0;
    busy        = 1'b0;
    done        = 1'b0;
    l1_ready    = 1'b0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_din    = '0;
    col_valid   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d  = ST_WRITE;
          wr_ptr_d = '0;
          gen_clr  = 1'b1;
        end
      end
      ST_WRITE: begin
        busy      = 1'b1;
        l1_ready  = 1'b1;
        bram_addr = wr_ptr_q;
        if (l1_valid) begin
          bram_we  = 1'b1;
          bram_din = l1_data;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RD0;
        end
      end
      ST_RD0: begin
        busy      = 1'b1;
        bram_addr = gen_addr;
        state_d   = ST_RD1;
      end
      ST_RD1: begin
        busy        = 1'b1;
        gen_row_sel = 2'd1;
        bram_addr   = gen_addr;
        state_d     = ST_RD2;
      end
      ST_RD2: begin
        busy        = 1'b1;
        gen_row_sel = 2'd2;
        bram_addr   = gen_addr;
        state_d     = ST_RD3;
      end
      ST_RD3: begin
        // Address parked on the last row so it stays constant through OUT.
        busy        = 1'b1;
        gen_row_sel = 2'd2;
        bram_addr   = gen_addr;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        busy        = 1'b1;
        gen_row_sel = 2'd2;
        bram_addr   = gen_addr;
        col_valid   = 1'b1;
        if (col_ready) begin
          gen_adv = 1'b1;
          state_d = gen_last ? ST_DONE : ST_RD0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    col_data = '0;
    col_data[col_row_lsb(0, DATA_W) +: DATA_W] = row0_q;
    col_data[col_row_lsb(1, DATA_W) +: DATA_W] = row1_q;
    col_data[col_row_lsb(2, DATA_W) +: DATA_W] = row2_q;
  end

  assign col_last  = gen_last;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_fmap_scheduler.sv
module tb_conv_fmap_scheduler;
  import conv_pkg::*;

  localparam int DW    = 8;
  localparam int IH    = 6;
  localparam int IW    = 6;
  localparam int NF    = 2;
  localparam int W1    = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NCOL  = 24;
  localparam int FW    = 1;
  localparam int CW    = 3 * DW;
  localparam int EW    = 1 + 2 + FW + CW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          l1_valid = 1'b0;
  logic [DW-1:0] l1_data = '0;
  logic          col_ready = 1'b0;
  logic [DW-1:0] bram_dout;
  logic          busy, done, l1_ready, bram_we, col_valid, col_last;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [CW-1:0] col_data;
  logic [FW-1:0] col_filter;
  logic [1:0]    col_k;
  state_e        dbg_state;

  always #5 clk = ~clk;

  conv_fmap_scheduler #(
    .DATA_W(DW), .IMG_H(IH), .IMG_W(IW), .NUM_FILTERS(NF), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_data(l1_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .col_valid(col_valid), .col_ready(col_ready),
    .col_data(col_data), .col_filter(col_filter), .col_k(col_k),
    .col_last(col_last), .dbg_state(dbg_state)
  );

  // Synchronous-read single-port BRAM.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  // ---------------- scoreboard ----------------
  typedef enum int {PH_IDLE, PH_WR, PH_RD, PH_DN} ph_e;
  int            checks = 0;
  int            errors = 0;
  ph_e           ph = PH_IDLE;
  int            wr_idx = 0;
  int            gap = 0;
  int            col_cnt = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_col [NCOL];
  logic [EW-1:0] model_col0;
  logic [EW-1:0] obs;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] stall_addr;

  assign obs = {col_last, col_k, col_filter, col_data};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected column stream from the written map: loops r, c, f, k with
  // row i of each column read from ((r+i)*W1 + c+k)*NF + f.
  function automatic void build_model();
    exp_q.delete();
    for (int r = 0; r <= IH - 5; r++)
      for (int c = 0; c <= IW - 5; c++)
        for (int f = 0; f < NF; f++)
          for (int k = 0; k < 3; k++) begin
            logic [CW-1:0] d;
            logic          last;
            for (int i = 0; i < 3; i++)
              d[i*DW +: DW] = model_mem[((r + i) * W1 + c + k) * NF + f];
            last = (r == IH - 5) && (c == IW - 5) && (f == NF - 1) && (k == 2);
            exp_q.push_back({last, 2'(k), FW'(f), d});
          end
    model_col0 = exp_q[0];
  endfunction

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    ph_e ph0;
    ph0 = ph;
    if (rst) begin
      ph = PH_IDLE;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("l1_ready", l1_ready, ph0 == PH_WR);
      check("busy", busy, (ph0 == PH_WR) || (ph0 == PH_RD));
      check("done", done, ph0 == PH_DN);
      if (ph0 == PH_WR) begin
        check("bram_we_wr", bram_we, l1_valid);
        if (l1_valid) begin
          check("wr_addr", bram_addr, wr_idx);
          check("wr_din", bram_din, l1_data);
          model_mem[wr_idx] = l1_data;
          wr_idx++;
          if (wr_idx == DEPTH) begin
            build_model();
            ph = PH_RD;
            gap = 0;
          end
        end
      end else begin
        check("bram_we_rd", bram_we, 1'b0);
        if (ph0 == PH_RD) begin
          gap++;
          check("col_valid", col_valid, gap >= 5);
          if (col_valid) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL col_extra: got %0h expected no column", obs);
            end else begin
              check("col_word", obs, exp_q[0]);
            end
            if (prev_stall) check("stall_addr", bram_addr, stall_addr);
            if (col_ready) begin
              if (col_cnt < NCOL) got_col[col_cnt] = obs;
              col_cnt++;
              if (exp_q.size() != 0) void'(exp_q.pop_front());
              gap = 0;
              prev_stall = 1'b0;
              if (col_last) ph = PH_DN;
            end else begin
              prev_stall = 1'b1;
              stall_addr = bram_addr;
            end
          end
        end else begin
          check("col_valid_off", col_valid, 1'b0);
        end
      end
      if (((ph0 == PH_IDLE) || (ph0 == PH_DN)) && start) begin
        ph = PH_WR;
        wr_idx = 0;
        col_cnt = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: col_ready = 1'b1;
      1: col_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (col_valid && stall_cnt < 7) begin
          col_ready = 1'b0;
          stall_cnt++;
        end else begin
          if (!col_valid) stall_cnt = 0;
          col_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic write_frame(input bit rnd, output int cycles);
    int i = 0;
    cycles = 0;
    while (i < DEPTH && cycles < 500) begin
      cycles++;
      if (rnd && $urandom_range(0, 3) == 0) begin
        l1_valid = 1'b0;
        l1_data  = 8'($urandom);
      end else begin
        l1_valid = 1'b1;
        l1_data  = rnd ? 8'($urandom) : 8'(i);
      end
      @(negedge clk);
      if (l1_valid && l1_ready) i++;
      @(posedge clk); #1;
    end
    l1_valid = 1'b0;
    check("write_complete", i, DEPTH);
  endtask

  task automatic wait_done(input bit noise);
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      l1_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    l1_valid = 1'b0;
    check("done_reached", done, 1'b1);
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_l1_ready", l1_ready, 1'b0);
    check("rst_we", bram_we, 1'b0);
    check("rst_addr", bram_addr, '0);
    check("rst_din", bram_din, '0);
    check("rst_col_valid", col_valid, 1'b0);
    check("rst_col_word", obs, '0);
  endtask

  task automatic pin_columns();
    check("col_count", col_cnt, NCOL);
    check("model_col0", model_col0, {1'b0, 2'd0, 1'b0, 8'd16, 8'd8, 8'd0});
    check("col0", got_col[0], {1'b0, 2'd0, 1'b0, 8'd16, 8'd8, 8'd0});
    check("col1", got_col[1], {1'b0, 2'd1, 1'b0, 8'd18, 8'd10, 8'd2});
    check("col3", got_col[3], {1'b0, 2'd0, 1'b1, 8'd17, 8'd9, 8'd1});
    check("col23", got_col[23], {1'b1, 2'd2, 1'b1, 8'd31, 8'd23, 8'd15});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_checks();

    // Frame 1: address-valued data, no bubbles, col_ready always high.
    @(posedge clk); #1;
    rdy_mode = 0;
    start_frame();
    write_frame(1'b0, cyc);
    check("write_cycles", cyc, DEPTH);
    wait_done(1'b0);
    pin_columns();

    // Frame 2: random data and bubbles, 7-cycle stall per column,
    // stray start and l1_valid during the read phase.
    rdy_mode = 2;
    start_frame();
    write_frame(1'b1, cyc);
    repeat (12) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1);
    check("col_count_f2", col_cnt, NCOL);

    // Frame 3: reset while fetching row 2 of the first column.
    rdy_mode = 0;
    start_frame();
    write_frame(1'b0, cyc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != ST_RD2 && n < 40);
    check("reached_rd2", dbg_state, ST_RD2);
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    reset_checks();

    // Frame 4: restart after reset, same data as frame 1.
    @(posedge clk); #1;
    start_frame();
    write_frame(1'b0, cyc);
    wait_done(1'b0);
    pin_columns();

    // Frame 5: random data, random backpressure.
    rdy_mode = 1;
    start_frame();
    write_frame(1'b1, cyc);
    wait_done(1'b1);
    check("col_count_f5", col_cnt, NCOL);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
